// File: rtl/mips_lsu_pkg.sv
// rtl/mips_lsu_pkg.sv - shared op/state encodings and helpers for the load/store unit
package mips_lsu_pkg;

    localparam logic [2:0] LSU_LB  = 3'd0;
    localparam logic [2:0] LSU_LH  = 3'd1;
    localparam logic [2:0] LSU_LW  = 3'd2;
    localparam logic [2:0] LSU_LBU = 3'd3;
    localparam logic [2:0] LSU_LHU = 3'd4;
    localparam logic [2:0] LSU_SB  = 3'd5;
    localparam logic [2:0] LSU_SH  = 3'd6;
    localparam logic [2:0] LSU_SW  = 3'd7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_STORE  = 3'd2;
    localparam logic [2:0] ST_RMW_RD = 3'd3;
    localparam logic [2:0] ST_RMW_WR = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    localparam int unsigned MEM_BYTES_DEFAULT = 1024;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] offset);
        case (op)
            LSU_LW, LSU_SW:          misaligned = (offset != 2'b00);
            LSU_LH, LSU_LHU, LSU_SH: misaligned = offset[0];
            default:                 misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// rtl/mips_lsu_if.sv - core request/response and data memory signals of the load/store unit
interface mips_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    // master: core plus data memory side; slave: the LSU itself
    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_a, mem_we, mem_wd
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_a, mem_we, mem_wd
    );
endinterface

// File: rtl/mips_lsu_lane_align.sv
// rtl/mips_lsu_lane_align.sv - big-endian lane extract/extend for loads and lane merge for stores
module mips_lsu_lane_align
    import mips_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        half_sel   = offset[1] ? word[15:0] : word[31:16];
        load_data  = word;
        store_word = word;
        case (op)
            LSU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: load_data = {24'h0, byte_sel};
            LSU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: load_data = {16'h0, half_sel};
            LSU_SB: begin
                case (offset)
                    2'd0:    store_word[31:24] = wdata[7:0];
                    2'd1:    store_word[23:16] = wdata[7:0];
                    2'd2:    store_word[15:8]  = wdata[7:0];
                    default: store_word[7:0]   = wdata[7:0];
                endcase
            end
            LSU_SH: begin
                if (offset[1]) store_word[15:0]  = wdata;
                else           store_word[31:16] = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - load/store unit FSM driving the word-wide data memory port
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    mips_lsu_if.slave bus
);
    logic [2:0]  state;
    lsu_req_t    req_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic        req_fault;
    logic [31:0] align_word;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_fault = misaligned(bus.req_op, bus.req_addr[1:0]) ||
                       (bus.req_addr >= 32'(MEM_BYTES));

    // The merge register feeds the aligner only while writing back a sub-word store
    assign align_word = (state == ST_RMW_WR) ? merge_q : bus.mem_rd;

    mips_lsu_lane_align u_align (
        .word       (align_word),
        .offset     (req_q.addr[1:0]),
        .op         (req_q.op),
        .wdata      (req_q.wdata[15:0]),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;
    assign bus.mem_a      = {req_q.addr[31:2], 2'b00};
    assign bus.mem_we     = (state == ST_STORE) || (state == ST_RMW_WR);
    assign bus.mem_wd     = (state == ST_STORE)  ? req_q.wdata :
                            (state == ST_RMW_WR) ? store_word  : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        req_q   <= '{op: bus.req_op, addr: bus.req_addr, wdata: bus.req_wdata};
                        rdata_q <= 32'h0;
                        fault_q <= req_fault;
                        if (req_fault)                                      state <= ST_RESP;
                        else if (bus.req_op == LSU_SW)                      state <= ST_STORE;
                        else if (bus.req_op == LSU_SB || bus.req_op == LSU_SH) state <= ST_RMW_RD;
                        else                                                state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    rdata_q <= load_data;
                    state   <= ST_RESP;
                end
                ST_STORE:  state <= ST_RESP;
                ST_RMW_RD: begin
                    merge_q <= bus.mem_rd;
                    state   <= ST_RMW_WR;
                end
                ST_RMW_WR: state <= ST_RESP;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_lsu.sv
// tb/tb_mips_lsu.sv - self-checking bench for the load/store unit
module tb_mips_lsu;
    import mips_lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    always #5 clk = ~clk;

    mips_lsu_if bus ();

    mips_lsu #(.MEM_BYTES(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:255];
    assign bus.mem_rd = mem[bus.mem_a[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8ABC1234;
        end else if (bus.mem_we) begin
            mem[bus.mem_a[9:2]] <= bus.mem_wd;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic fault, output int lat,
                         output logic we_seen);
        int n;
        rdata   = 32'h0;
        fault   = 1'b0;
        lat     = -1;
        we_seen = 1'b0;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (bus.mem_we) we_seen = 1'b1;
            if (bus.resp_valid) begin
                rdata = bus.resp_rdata;
                fault = bus.resp_fault;
                lat   = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[22];

    logic [31:0] rdata;
    logic        fault;
    int          lat;
    logic        we_seen;

    initial begin
        vecs[0]  = '{LSU_LB,  32'h10,  32'h0,        32'hFFFFFF8A, 1'b0, 2, 32'h8ABC1234};
        vecs[1]  = '{LSU_LBU, 32'h10,  32'h0,        32'h0000008A, 1'b0, 2, 32'h8ABC1234};
        vecs[2]  = '{LSU_LB,  32'h13,  32'h0,        32'h00000034, 1'b0, 2, 32'h8ABC1234};
        vecs[3]  = '{LSU_LH,  32'h10,  32'h0,        32'hFFFF8ABC, 1'b0, 2, 32'h8ABC1234};
        vecs[4]  = '{LSU_LHU, 32'h10,  32'h0,        32'h00008ABC, 1'b0, 2, 32'h8ABC1234};
        vecs[5]  = '{LSU_LH,  32'h12,  32'h0,        32'h00001234, 1'b0, 2, 32'h8ABC1234};
        vecs[6]  = '{LSU_LW,  32'h10,  32'h0,        32'h8ABC1234, 1'b0, 2, 32'h8ABC1234};
        vecs[7]  = '{LSU_SB,  32'h11,  32'hFFFFFFEE, 32'h0,        1'b0, 3, 32'h8AEE1234};
        vecs[8]  = '{LSU_SH,  32'h12,  32'h0000CAFE, 32'h0,        1'b0, 3, 32'h8AEECAFE};
        vecs[9]  = '{LSU_LW,  32'h10,  32'h0,        32'h8AEECAFE, 1'b0, 2, 32'h8AEECAFE};
        vecs[10] = '{LSU_LB,  32'h12,  32'h0,        32'hFFFFFFCA, 1'b0, 2, 32'h8AEECAFE};
        vecs[11] = '{LSU_LHU, 32'h12,  32'h0,        32'h0000CAFE, 1'b0, 2, 32'h8AEECAFE};
        vecs[12] = '{LSU_LW,  32'h11,  32'h0,        32'h0,        1'b1, 1, 32'h8AEECAFE};
        vecs[13] = '{LSU_SH,  32'h13,  32'h00001111, 32'h0,        1'b1, 1, 32'h8AEECAFE};
        vecs[14] = '{LSU_SW,  32'h400, 32'hA5A5A5A5, 32'h0,        1'b1, 1, 32'h00000000};
        vecs[15] = '{LSU_LB,  32'h400, 32'h0,        32'h0,        1'b1, 1, 32'h00000000};
        vecs[16] = '{LSU_SW,  32'h3FC, 32'h11223344, 32'h0,        1'b0, 2, 32'h11223344};
        vecs[17] = '{LSU_LBU, 32'h3FF, 32'h0,        32'h00000044, 1'b0, 2, 32'h11223344};
        vecs[18] = '{LSU_SB,  32'h3FC, 32'h00000099, 32'h0,        1'b0, 3, 32'h99223344};
        vecs[19] = '{LSU_LH,  32'h3FE, 32'h0,        32'h00003344, 1'b0, 2, 32'h99223344};
        vecs[20] = '{LSU_SH,  32'h10,  32'h00008001, 32'h0,        1'b0, 3, 32'h8001CAFE};
        vecs[21] = '{LSU_LH,  32'h10,  32'h0,        32'hFFFF8001, 1'b0, 2, 32'h8001CAFE};

        reset         = 1'b1;
        mem_init      = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;

        check("reset req_ready",  {31'h0, bus.req_ready},  32'h1);
        check("reset resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("reset resp_rdata", bus.resp_rdata,          32'h0);
        check("reset resp_fault", {31'h0, bus.resp_fault}, 32'h0);
        check("reset mem_we",     {31'h0, bus.mem_we},     32'h0);
        check("reset mem_a",      bus.mem_a,               32'h0);
        check("reset mem_wd",     bus.mem_wd,              32'h0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            do_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, rdata, fault, lat, we_seen);
            check($sformatf("v%0d rdata", i),   rdata,               vecs[i].exp_rdata);
            check($sformatf("v%0d fault", i),   {31'h0, fault},      {31'h0, vecs[i].exp_fault});
            check($sformatf("v%0d latency", i), 32'(lat),            32'(vecs[i].exp_lat));
            check($sformatf("v%0d mem_we", i),  {31'h0, we_seen},
                  {31'h0, (vecs[i].op >= LSU_SB) && !vecs[i].exp_fault});
            @(negedge clk);
            check($sformatf("v%0d mem word", i), mem[vecs[i].addr[9:2]], vecs[i].exp_word);
        end

        // Reset landing in the RMW_RD cycle of SB 0x10 must abort before any write
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = LSU_SB;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h00000055;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rmw_rd mem_we", {31'h0, bus.mem_we}, 32'h0);
        reset = 1'b1;
        #1;
        check("midreset req_ready",  {31'h0, bus.req_ready},  32'h1);
        check("midreset resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("midreset mem_we",     {31'h0, bus.mem_we},     32'h0);
        check("midreset mem_a",      bus.mem_a,               32'h0);
        check("midreset mem_wd",     bus.mem_wd,              32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset word 0x10", mem[4], 32'h8001CAFE);
        do_op(LSU_LW, 32'h10, 32'h0, rdata, fault, lat, we_seen);
        check("after reset LW rdata", rdata, 32'h8001CAFE);
        check("after reset LW lat",   32'(lat), 32'd2);

        // Back-to-back LW, SW, LW with req_valid held high
        begin
            logic [2:0]  b_op [3];
            logic [31:0] b_addr [3];
            logic [31:0] b_wd [3];
            logic [31:0] b_exp [3];
            int acc_cyc [3];
            int acc, rsp, cyc, viol;
            logic pend, busy;
            b_op   = '{LSU_LW, LSU_SW, LSU_LW};
            b_addr = '{32'h3FC, 32'h14, 32'h14};
            b_wd   = '{32'h0, 32'hDEADBEEF, 32'h0};
            b_exp  = '{32'h99223344, 32'h0, 32'hDEADBEEF};
            acc = 0; rsp = 0; cyc = 0; viol = 0; pend = 1'b0; busy = 1'b0;
            acc_cyc = '{0, 0, 0};
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = b_op[0];
            bus.req_addr  = b_addr[0];
            bus.req_wdata = b_wd[0];
            pend = bus.req_ready;
            while (rsp < 3 && cyc < 60) begin
                @(negedge clk);
                cyc++;
                if (pend) begin
                    pend = 1'b0;
                    busy = 1'b1;
                    if (acc < 3) acc_cyc[acc] = cyc;
                    acc++;
                    if (acc < 3) begin
                        bus.req_op    = b_op[acc];
                        bus.req_addr  = b_addr[acc];
                        bus.req_wdata = b_wd[acc];
                    end else begin
                        bus.req_valid = 1'b0;
                    end
                end
                if (busy && bus.req_ready) viol++;
                if (bus.resp_valid) begin
                    if (rsp < 3) check($sformatf("b2b resp%0d rdata", rsp), bus.resp_rdata, b_exp[rsp]);
                    rsp++;
                    busy = 1'b0;
                end
                if (bus.req_ready && bus.req_valid && !busy) pend = 1'b1;
            end
            bus.req_valid = 1'b0;
            repeat (3) @(negedge clk);
            check("b2b accepts",        32'(acc),                    32'd3);
            check("b2b responses",      32'(rsp),                    32'd3);
            check("b2b ready while busy", 32'(viol),                 32'd0);
            check("b2b gap 0-1",        32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check("b2b gap 1-2",        32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
            check("b2b word 0x14",      mem[5],                      32'hDEADBEEF);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
